// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared types and constants for phase_seq_arbiter.
//   state_e      controller states
//   PH_*         engine phase codes
//   DEF_*        default parameter values
//   phase_of()   expected engine phase for a controller state
package phase_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PH1   = 3'd2,
    PH2   = 3'd3,
    DWELL = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [2:0] PH_IDLE  = 3'b001;
  localparam logic [2:0] PH_ONE   = 3'b010;
  localparam logic [2:0] PH_TWO   = 3'b100;
  localparam logic [2:0] PH_THREE = 3'b111;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_DWELL_W = 4;

  function automatic logic [2:0] phase_of(input state_e s);
    logic [2:0] ph;
    case (s)
      PH1:     ph = PH_ONE;
      PH2:     ph = PH_TWO;
      DWELL:   ph = PH_THREE;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/phase_seq_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select.
//   req       in   NREQ   request vector
//   last_ptr  in   PTR_W  index of the requester granted last
//   gnt       out  NREQ   one-hot winner, zero when no request
// The search begins at the requester after last_ptr and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W-1:0] pos;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = PTR_W'((32'(last_ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_seq_arbiter.sv
// phase_seq_arbiter: shares one four-phase stepping engine among NREQ
// requesters. Round-robin grant, then one start/step2/step3 cycle for the
// winner with a per-requester dwell in the final phase.
//   clk        in   1             rising-edge clock
//   clr        in   1             async active-high reset
//   req        in   NREQ          level requests
//   dwell      in   NREQ*DWELL_W  dwell counts, requester i at [i*DWELL_W +: DWELL_W]
//   abort      in   1             cancel current operation (PHASE_SEQ_ABORT_EN only)
//   start      out  1             engine start pulse
//   step2      out  1             engine step2 control
//   step3      out  1             engine step3 control
//   grant      out  NREQ          one-hot engine owner, zero when idle
//   busy       out  1             high in every non-IDLE state
//   done       out  1             one-cycle completion pulse
//   aborted    out  1             qualifies done: operation was cancelled
//   phase_out  out  3             expected engine phase code
// Build option: define PHASE_SEQ_ABORT_EN to enable abort handling;
// otherwise abort is ignored and aborted is held low.
module phase_seq_arbiter
  import phase_seq_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned DWELL_W = DEF_DWELL_W
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DWELL_W-1:0] dwell,
  input  logic                    abort,
  output logic                    start,
  output logic                    step2,
  output logic                    step3,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [2:0]              phase_out
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [PTR_W-1:0]   last_q, last_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [DWELL_W-1:0] arb_dwell;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req      (req),
    .last_ptr (last_q),
    .gnt      (arb_gnt)
  );

  // Winner index and its dwell slice, decoded from the one-hot grant.
  always_comb begin
    arb_idx   = '0;
    arb_dwell = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        arb_idx   = k[PTR_W-1:0];
        arb_dwell = dwell[k*DWELL_W +: DWELL_W];
      end
    end
  end

`ifdef PHASE_SEQ_ABORT_EN
  logic abrt_q, abrt_d;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      win_q   <= '0;
      // Pointing at the last requester gives requester 0 top priority.
      last_q  <= PTR_W'(NREQ - 1);
`ifdef PHASE_SEQ_ABORT_EN
      abrt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      last_q  <= last_d;
`ifdef PHASE_SEQ_ABORT_EN
      abrt_q  <= abrt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    win_d   = win_q;
    last_d  = last_q;
`ifdef PHASE_SEQ_ABORT_EN
    abrt_d  = abrt_q;
`endif
    start   = 1'b0;
    step2   = 1'b0;
    step3   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = arb_gnt;
          win_d   = arb_idx;
          cnt_d   = arb_dwell;
          state_d = START;
`ifdef PHASE_SEQ_ABORT_EN
          abrt_d  = 1'b0;
`endif
        end
      end
      START: begin
        start   = 1'b1;
        state_d = PH1;
`ifdef PHASE_SEQ_ABORT_EN
        if (abort) begin
          state_d = DONE;
          abrt_d  = 1'b1;
        end
`endif
      end
      PH1: begin
        state_d = PH2;
`ifdef PHASE_SEQ_ABORT_EN
        if (abort) begin
          state_d = DONE;
          abrt_d  = 1'b1;
        end
`endif
      end
      PH2: begin
        step2   = 1'b1;
        state_d = DWELL;
`ifdef PHASE_SEQ_ABORT_EN
        // Withholding step2 lets the engine fall back to phase 001.
        if (abort) begin
          step2   = 1'b0;
          state_d = DONE;
          abrt_d  = 1'b1;
        end
`endif
      end
      DWELL: begin
        if (cnt_q == '0) begin
          step3   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`ifdef PHASE_SEQ_ABORT_EN
        if (abort) begin
          step3   = 1'b1;
          state_d = DONE;
          abrt_d  = 1'b1;
        end
`endif
      end
      DONE: begin
        last_d  = win_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign phase_out = phase_of(state_q);

`ifdef PHASE_SEQ_ABORT_EN
  assign aborted = done & abrt_q;
`else
  assign aborted = 1'b0;
`endif

endmodule
